// File: rtl/ring_sequencer_ctrl.sv
// ----------------------------------------------------------------------------
// ring_sequencer_ctrl
//
// Purpose:
//   Seven-bit ring sequencer. A pattern is shifted in serially while load is
//   high. While run is high the pattern then rotates one position per step,
//   in either direction, with a programmable step rate. A one-clock wrap pulse
//   follows every WRAP_LEN-th step.
//
// Ports:
//   io_in[0]    clock, rising edge active
//   io_in[1]    rst_n, asynchronous active-low reset
//   io_in[2]    load  : serial-load request (level)
//   io_in[3]    din   : serial data bit shifted into ring[0] during load
//   io_in[4]    run   : run enable (level)
//   io_in[5]    dir   : 0 = rotate left (bit6 -> bit0), 1 = rotate right
//   io_in[7:6]  rate  : one step every 2^rate clocks
//   io_out[6:0] ring state (registered)
//   io_out[7]   wrap pulse (registered, one clock)
//
// Parameters:
//   WRAP_LEN  steps per wrap pulse, 2..15
//   SEED      pattern loaded into an all-zero ring on entry to RUN
//             (only when auto-seed is compiled in)
//
// Configuration macro:
//   RING_SEQUENCER_AUTO_SEED_EN  when defined, an all-zero ring is replaced
//                                by SEED on the IDLE->RUN and HOLD->RUN edges.
//                                When undefined, zeros rotate unchanged.
// ----------------------------------------------------------------------------
module ring_sequencer_ctrl #(
    parameter int         WRAP_LEN = 7,
    parameter logic [6:0] SEED     = 7'b0000001
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

`ifdef RING_SEQUENCER_AUTO_SEED_EN
    localparam bit AUTO_SEED_ON = 1'b1;
`else
    localparam bit AUTO_SEED_ON = 1'b0;
`endif

    localparam logic [3:0] LAST_STEP = 4'(WRAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       din;
    logic       run;
    logic       dir;
    logic [1:0] rate;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign load  = io_in[2];
    assign din   = io_in[3];
    assign run   = io_in[4];
    assign dir   = io_in[5];
    assign rate  = io_in[7:6];

    state_t     state_q;
    logic [6:0] ring_q;
    logic [2:0] presc_q;
    logic [3:0] step_q;
    logic       wrap_q;

    logic [2:0] presc_lim;
    logic       step_due;
    logic [6:0] ring_step_d;
    logic [6:0] ring_entry_d;

    always_comb begin
        // Terminal prescaler count for the current rate: 0, 1, 3 or 7.
        presc_lim = 3'((4'd1 << rate) - 4'd1);
        // ">=" rather than "==" so that lowering rate mid-count steps on the
        // very next edge instead of wrapping the prescaler around.
        step_due  = (presc_q >= presc_lim);

        if (dir) begin
            ring_step_d = {ring_q[0], ring_q[6:1]};
        end else begin
            ring_step_d = {ring_q[5:0], ring_q[6]};
        end

        if (AUTO_SEED_ON && (ring_q == 7'd0)) begin
            ring_entry_d = SEED;
        end else begin
            ring_entry_d = ring_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ring_q  <= 7'd0;
            presc_q <= 3'd0;
            step_q  <= 4'd0;
            wrap_q  <= 1'b0;
        end else if (load) begin
            // Load wins over everything, regardless of the current state.
            state_q <= LOAD;
            ring_q  <= {ring_q[5:0], din};
            presc_q <= 3'd0;
            step_q  <= 4'd0;
            wrap_q  <= 1'b0;
        end else begin
            // The wrap pulse is only ever set by a wrapping step below.
            wrap_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    state_q <= IDLE;
                end
                IDLE: begin
                    if (run) begin
                        // Entry edge: no step, prescaler starts from zero.
                        state_q <= RUN;
                        presc_q <= 3'd0;
                        ring_q  <= ring_entry_d;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // Ring, prescaler and step count freeze in HOLD.
                        state_q <= HOLD;
                    end else if (step_due) begin
                        ring_q  <= ring_step_d;
                        presc_q <= 3'd0;
                        if (step_q == LAST_STEP) begin
                            step_q <= 4'd0;
                            wrap_q <= 1'b1;
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end else begin
                        presc_q <= presc_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (run) begin
                        // Resume with the frozen prescaler; the resume edge
                        // itself does not count toward the step spacing.
                        state_q <= RUN;
                        ring_q  <= ring_entry_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io_out = {wrap_q, ring_q};

endmodule

// File: tb/tb_ring_sequencer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ring_sequencer_ctrl
//
// Self-checking bench for ring_sequencer_ctrl with default parameters.
// A behavioural model (mode, ring, clocks-since-last-step, total steps) is
// advanced on every clock edge from the same inputs the DUT sees; the DUT
// output is compared to the model one time unit after each rising edge.
// Directed scenarios also compare against literal expected patterns.
// ----------------------------------------------------------------------------
module tb_ring_sequencer_ctrl;

    localparam int         WRAP_LEN = 7;
    localparam logic [6:0] SEED     = 7'b0000001;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       load  = 1'b0;
    logic       din   = 1'b0;
    logic       run   = 1'b0;
    logic       dir   = 1'b0;
    logic [1:0] rate  = 2'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_checks = 0;
    int n_fail   = 0;

    assign io_in = {rate, dir, run, din, load, rst_n, clk};

    ring_sequencer_ctrl #(
        .WRAP_LEN(WRAP_LEN),
        .SEED    (SEED)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 load, 2 run, 3 hold
    int         m_mode;
    logic [6:0] m_ring;
    int         m_since;   // active run clocks since the last step
    int         m_steps;   // steps since the last load/reset
    bit         m_wrap;

    function automatic logic [6:0] rot_left(input logic [6:0] r);
        int v;
        v = int'(r);
        return 7'(((v * 2) + (v / 64)) % 128);
    endfunction

    function automatic logic [6:0] rot_right(input logic [6:0] r);
        int v;
        v = int'(r);
        return 7'((v / 2) + ((v % 2) * 64));
    endfunction

    function automatic logic [7:0] m_out();
        return {m_wrap, m_ring};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_ring  = 7'd0;
        m_since = 0;
        m_steps = 0;
        m_wrap  = 1'b0;
    endtask

    task automatic model_seed();
`ifdef RING_SEQUENCER_AUTO_SEED_EN
        if (m_ring == 7'd0) m_ring = SEED;
`endif
    endtask

    task automatic model_edge();
        m_wrap = 1'b0;
        if (load) begin
            m_ring  = 7'((int'(m_ring) * 2 + int'(din)) % 128);
            m_since = 0;
            m_steps = 0;
            m_mode  = 1;
        end else if (m_mode == 1) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (run) begin
                m_mode  = 2;
                m_since = 0;
                model_seed();
            end
        end else if (m_mode == 2) begin
            if (!run) begin
                m_mode = 3;
            end else begin
                m_since = m_since + 1;
                if (m_since >= (1 << rate)) begin
                    m_ring  = dir ? rot_right(m_ring) : rot_left(m_ring);
                    m_since = 0;
                    m_steps = m_steps + 1;
                    m_wrap  = ((m_steps % WRAP_LEN) == 0);
                end
            end
        end else begin
            if (run) begin
                m_mode = 2;
                model_seed();
            end
        end
    endtask

    // Drive one clock's inputs, take the edge, advance the model.
    task automatic tick(input logic l, input logic d, input logic r,
                        input logic dr, input logic [1:0] rt);
        load = l;
        din  = d;
        run  = r;
        dir  = dr;
        rate = rt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset held across one rising edge; returns 1 time unit after that edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        load = 1'b0;
        run  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (io_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: io_out=%b expected %b", io_out, 8'h00);
        end
        load = 1'b1;
        din  = 1'b1;
        run  = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (io_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held_edge: io_out=%b expected %b", io_out, 8'h00);
        end
        load  = 1'b0;
        run   = 1'b0;
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 2'd0);
        n_checks++;
        if (io_out !== m_out() || io_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_first_edge: io_out=%b expected %b", io_out, 8'h00);
        end
    endtask

    task automatic test_load();
        logic [6:0] pat;
        pat = 7'b1011001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            tick(1, pat[i], 0, 0, 2'd0);
            n_checks++;
            if (io_out !== m_out()) begin
                n_fail++;
                $display("FAIL load_shift bit %0d: io_out=%b expected %b", i, io_out, m_out());
            end
        end
        tick(0, 0, 0, 0, 2'd0);
        n_checks++;
        if (io_out !== 8'b0101_1001 || io_out !== m_out()) begin
            n_fail++;
            $display("FAIL load_result: io_out=%b expected %b", io_out, 8'b0101_1001);
        end
        // From IDLE the entry edge must not step.
        tick(0, 0, 1, 0, 2'd0);
        n_checks++;
        if (io_out !== 8'b0101_1001) begin
            n_fail++;
            $display("FAIL load_idle_entry: io_out=%b expected %b", io_out, 8'b0101_1001);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp;
        do_reset();
        tick(1, 1, 0, 0, 2'd0);
        tick(0, 0, 0, 0, 2'd0);
        tick(0, 0, 1, 0, 2'd0);
        n_checks++;
        if (io_out !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL rotate_entry: io_out=%b expected %b", io_out, 8'b0000_0001);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, 0, 2'd0);
            exp = {(i == 6), 7'(1 << ((i + 1) % 7))};
            n_checks++;
            if (io_out !== exp || io_out !== m_out()) begin
                n_fail++;
                $display("FAIL rotate_left step %0d: io_out=%b expected %b", i, io_out, exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] run_seq;
        logic [6:0] exp_ring [8];
        do_reset();
        tick(1, 1, 0, 0, 2'd2);
        tick(0, 0, 0, 0, 2'd2);
        tick(0, 0, 1, 0, 2'd2);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 0, 2'd2);
            n_checks++;
            if (io_out !== {1'b0, (i == 3) ? 7'd2 : 7'd1}) begin
                n_fail++;
                $display("FAIL hold_rate2 clk %0d: io_out=%b expected ring %0d", i, io_out, (i == 3) ? 2 : 1);
            end
        end
        // two active, three held, resume edge, two more active -> step
        run_seq  = 8'b1110_0011;
        exp_ring = '{7'd2, 7'd2, 7'd2, 7'd2, 7'd2, 7'd2, 7'd2, 7'd4};
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, run_seq[i], 0, 2'd2);
            n_checks++;
            if (io_out !== {1'b0, exp_ring[i]} || io_out !== m_out()) begin
                n_fail++;
                $display("FAIL hold_resume clk %0d: io_out=%b expected %b", i, io_out, {1'b0, exp_ring[i]});
            end
        end
    endtask

    task automatic test_rate_dir();
        do_reset();
        tick(1, 1, 0, 0, 2'd3);
        tick(0, 0, 0, 0, 2'd3);
        tick(0, 0, 1, 0, 2'd3);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 2'd3);
        n_checks++;
        if (io_out !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL rate_precount: io_out=%b expected %b", io_out, 8'b0000_0001);
        end
        tick(0, 0, 1, 0, 2'd1);
        n_checks++;
        if (io_out !== 8'b0000_0010 || io_out !== m_out()) begin
            n_fail++;
            $display("FAIL rate_lowered: io_out=%b expected %b", io_out, 8'b0000_0010);
        end
        tick(0, 0, 1, 1, 2'd0);
        n_checks++;
        if (io_out !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL dir_flip: io_out=%b expected %b", io_out, 8'b0000_0001);
        end
        tick(0, 0, 1, 1, 2'd0);
        n_checks++;
        if (io_out !== 8'b0100_0000 || io_out !== m_out()) begin
            n_fail++;
            $display("FAIL dir_right_wrap: io_out=%b expected %b", io_out, 8'b0100_0000);
        end
    endtask

    task automatic test_load_in_run();
        do_reset();
        tick(1, 1, 0, 0, 2'd0);
        tick(0, 0, 0, 0, 2'd0);
        tick(0, 0, 1, 0, 2'd0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 2'd0);
        tick(1, 1, 1, 0, 2'd0);
        n_checks++;
        if (io_out !== 8'b0001_0001) begin
            n_fail++;
            $display("FAIL load_in_run: io_out=%b expected %b", io_out, 8'b0001_0001);
        end
        tick(0, 0, 1, 0, 2'd0);
        tick(0, 0, 1, 0, 2'd0);
        for (int i = 0; i < 9; i++) begin
            tick(0, 0, 1, 0, 2'd0);
            n_checks++;
            if (io_out !== m_out() || io_out[7] !== (i == 6)) begin
                n_fail++;
                $display("FAIL load_in_run_counters step %0d: io_out=%b expected %b", i, io_out, m_out());
            end
        end
        // Async reset mid-run, checked before any further edge.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (io_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_run: io_out=%b expected %b", io_out, 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 1, 0, 2'd0);
        n_checks++;
        if (io_out !== m_out()) begin
            n_fail++;
            $display("FAIL reset_mid_run_after: io_out=%b expected %b", io_out, m_out());
        end
    endtask

    task automatic test_auto_seed();
        int         wraps;
        logic [7:0] exp_entry;
`ifdef RING_SEQUENCER_AUTO_SEED_EN
        exp_entry = {1'b0, SEED};
`else
        exp_entry = 8'h00;
`endif
        do_reset();
        tick(0, 0, 1, 0, 2'd0);
        n_checks++;
        if (io_out !== exp_entry) begin
            n_fail++;
            $display("FAIL seed_entry: io_out=%b expected %b", io_out, exp_entry);
        end
        wraps = 0;
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, 1, 0, 2'd0);
            if (io_out[7] === 1'b1) wraps++;
            n_checks++;
            if (io_out !== m_out()) begin
                n_fail++;
                $display("FAIL seed_run step %0d: io_out=%b expected %b", i, io_out, m_out());
            end
        end
        n_checks++;
        if (wraps !== 1) begin
            n_fail++;
            $display("FAIL seed_wrap_count: wraps=%0d expected 1", wraps);
        end
    endtask

    task automatic test_random();
        logic l, d, r, dr;
        logic [1:0] rt;
        dr = 1'b0;
        rt = 2'd0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                n_checks++;
                if (io_out !== 8'h00) begin
                    n_fail++;
                    $display("FAIL random_reset cycle %0d: io_out=%b expected %b", i, io_out, 8'h00);
                end
            end
            l = ($urandom_range(0, 19) == 0);
            d = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) dr = ~dr;
            if ($urandom_range(0, 15) == 0) rt = 2'($urandom_range(0, 3));
            tick(l, d, r, dr, rt);
            n_checks++;
            if (io_out !== m_out()) begin
                n_fail++;
                $display("FAIL random cycle %0d: io_out=%b expected %b", i, io_out, m_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_rotate();
        test_hold();
        test_rate_dir();
        test_load_in_run();
        test_auto_seed();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_sequencer_ctrl.md
RING_SEQUENCER_CTRL -- requirements
Module: ring_sequencer_ctrl

Interface
- REQ-001: Parameter WRAP_LEN, default 7: number of ring steps per wrap pulse; legal range 2..15.
- REQ-002: Parameter SEED, default 7'b0000001: seed pattern used by the AUTO_SEED_EN feature.
- REQ-003: io_in[0]  input  1  clock; all state updates on the rising edge.
- REQ-004: io_in[1]  input  1  rst_n; asynchronous, active-low reset.
- REQ-005: io_in[2]  input  1  load; serial-load request, level-sensitive.
- REQ-006: io_in[3]  input  1  din; serial data bit shifted in during load.
- REQ-007: io_in[4]  input  1  run; run enable, level-sensitive.
- REQ-008: io_in[5]  input  1  dir; 0 = rotate left (bit6->bit0), 1 = rotate right (bit0->bit6).
- REQ-009: io_in[7:6]  input  2  rate; one step every 2^rate clocks (1, 2, 4 or 8).
- REQ-010: io_out[6:0]  output  7  ring state, active-high, registered.
- REQ-011: io_out[7]  output  1  wrap; one-clock pulse, registered.
- REQ-012: Inputs are synchronous to io_in[0]; the block contains no input synchronisers.

Function
- REQ-013: FSM states are IDLE, LOAD, RUN and HOLD; the encoding is free.
- REQ-014: Load priority: in any state, load=1 on an edge shall shift ring <= {ring[5:0], din}, clear the prescaler and step counter, and enter or stay in LOAD.
- REQ-015: LOAD with load=0: go to IDLE; the ring is unchanged on that edge.
- REQ-016: IDLE with load=0 and run=1: go to RUN with the prescaler at 0; no step occurs on the entry edge.
- REQ-017: RUN with load=0 and run=1: prescaler increments each clock.
- REQ-018: Step condition: prescaler >= 2^rate-1. On a step the ring rotates by one in direction dir and the prescaler returns to 0.
- REQ-019: The ">=" compare guarantees a step on the next edge when rate is lowered mid-count.
- REQ-020: dir and rate are sampled on each edge; a change takes effect on the next step, with no stall or extra step.
- REQ-021: Step counter increments on each step; on the step where it equals WRAP_LEN-1 it returns to 0 and io_out[7]=1 for exactly the following clock.
- REQ-022: RUN with run=0 and load=0: go to HOLD; ring, prescaler and step counter are frozen; io_out[7] is 0.
- REQ-023: HOLD with run=1 and load=0: return to RUN, resuming from the frozen prescaler value.
- REQ-024: HOLD with run=0 and load=0: stay in HOLD.
- REQ-025: io_out[7] is 0 in every cycle except the single cycle after a wrap step.
- REQ-026: Throughput: at rate=0 the ring steps every clock, so one wrap pulse occurs per WRAP_LEN clocks.

Reset
- REQ-027: rst_n=0 asynchronously forces state IDLE, ring=0, prescaler=0, step counter=0, io_out=8'h00.
- REQ-028: After rst_n deasserts, the first rising edge is evaluated normally from IDLE.
- REQ-029: Reset asserted mid-RUN or mid-LOAD discards all progress; no wrap pulse is emitted.

Configuration
- REQ-030: Macro RING_SEQUENCER_AUTO_SEED_EN compiles in or out the auto-seed feature.
- REQ-031: Defined: on the IDLE->RUN or HOLD->RUN edge, if ring == 0, the ring shall load SEED.
- REQ-032: Not defined: an all-zero ring runs unchanged (rotating zeros); wrap pulses still occur.

Verification
- REQ-033: Reset, then load=1 for 7 clocks with din = 1,0,1,1,0,0,1, then load=0 -> io_out[6:0]=7'b1011001, state IDLE, io_out[7]=0.
- REQ-034: Ring 7'b0000001, run=1, dir=0, rate=0 -> ring 0000010, 0000100, ..., 1000000, 0000001 on successive clocks; io_out[7]=1 only in the cycle after the 7th step.
- REQ-035: rate=2, run=1 -> one step every 4 clocks. Drop run for 3 clocks mid-count, then reassert -> prescaler resumes and the total step spacing is 4 active clocks.
- REQ-036: RUN at rate=3 with prescaler=5, switch rate to 1 -> step on the next edge. Flip dir mid-run -> the next step is in the new direction.
- REQ-037: Assert load=1 with din=1 during RUN -> shift-in on that edge, counters cleared, no wrap pulse. Assert rst_n=0 mid-RUN -> io_out=8'h00 immediately, without waiting for a clock edge.
- REQ-038: Ring=0, run=1 -> ring=SEED on the entry edge with RING_SEQUENCER_AUTO_SEED_EN defined; ring stays 0 without it.
